// File: rtl/colour_classifier.sv
// colour_classifier
// Steps a TCS-style frequency-output colour sensor through its red, blue and
// green filters. For each filter it waits a settle period and then counts the
// rising edges of the sensor output over a fixed window. From the three counts
// it classifies the patch as white, red, green, blue or none. The result and
// the raw counts are held until the next accepted measure request.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   sensor   in   asynchronous sensor frequency output
//   measure  in   start request, accepted only in IDLE or DONE
//   S2, S3   out  filter select {S2,S3}: red 00, blue 01, green 11
//   busy     out  high from the cycle after acceptance until valid
//   color    out  000 white, 001 red, 010 green, 011 blue, 100 none
//   r_cnt, b_cnt, g_cnt  out  latched edge counts (saturating)
//   valid    out  result available, held until the next accepted measure
//
// Optional feature macro: CSENSE_DEGLITCH_EN
//   Defined:     the filtered sensor level changes only after the synchronised
//                input has held its new value for 3 consecutive cycles.
//   Not defined: the filtered level is the synchroniser output.

module colour_classifier #(
  parameter int WINDOW    = 600000,
  parameter int SETTLE    = 1000,
  parameter int CNT_W     = 10,
  parameter int WHITE_TH  = 65,
  parameter int RED_TH    = 45,
  parameter int BLUE_TH   = 40,
  parameter int GREEN_MIN = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor,
  input  logic             measure,
  output logic             S2,
  output logic             S3,
  output logic             busy,
  output logic [2:0]       color,
  output logic [CNT_W-1:0] r_cnt,
  output logic [CNT_W-1:0] b_cnt,
  output logic [CNT_W-1:0] g_cnt,
  output logic             valid
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    PH_SETTLE,
    PH_MEAS,
    DECIDE,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    F_RED,
    F_BLUE,
    F_GREEN
  } filter_t;

  localparam logic [2:0] COL_WHITE = 3'b000;
  localparam logic [2:0] COL_RED   = 3'b001;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_BLUE  = 3'b011;
  localparam logic [2:0] COL_NONE  = 3'b100;

  // The phase timer only ever holds (length - 1), so TMAX values need clog2(TMAX) bits.
  localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]    SETTLE_LOAD = TW'(SETTLE - 1);
  localparam logic [TW-1:0]    WINDOW_LOAD = TW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           r_state;
  state_t           w_nextState;
  filter_t          r_filter;
  logic [TW-1:0]    r_timer;
  logic             w_timerDone;

  logic             r_sync1;
  logic             r_sync2;
  logic             w_filt;
  logic             r_prev;
  logic             w_rise;

  logic [CNT_W-1:0] r_redCnt;
  logic [CNT_W-1:0] r_blueCnt;
  logic [CNT_W-1:0] r_greenCnt;

  logic [2:0]       w_color;
  logic [2:0]       r_color;
  logic [CNT_W-1:0] r_redOut;
  logic [CNT_W-1:0] r_blueOut;
  logic [CNT_W-1:0] r_greenOut;
  logic             r_busy;
  logic             r_valid;

  // Two-flop synchroniser for the asynchronous sensor output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sensor;
      r_sync2 <= r_sync1;
    end
  end

`ifdef CSENSE_DEGLITCH_EN
  logic       r_filt;
  logic [1:0] r_dgCnt;

  // r_dgCnt counts consecutive cycles on which the synchronised level disagrees
  // with the filtered level; the third such cycle commits the new level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt  <= 1'b0;
      r_dgCnt <= 2'd0;
    end else if (r_sync2 != r_filt) begin
      if (r_dgCnt == 2'd2) begin
        r_filt  <= r_sync2;
        r_dgCnt <= 2'd0;
      end else begin
        r_dgCnt <= r_dgCnt + 2'd1;
      end
    end else begin
      r_dgCnt <= 2'd0;
    end
  end

  assign w_filt = r_filt;
`else
  assign w_filt = r_sync2;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_filt;
    end
  end

  assign w_rise      = w_filt & ~r_prev;
  assign w_timerDone = (r_timer == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (measure) begin
          w_nextState = START;
        end
      end
      START: begin
        w_nextState = PH_SETTLE;
      end
      PH_SETTLE: begin
        if (w_timerDone) begin
          w_nextState = PH_MEAS;
        end
      end
      PH_MEAS: begin
        if (w_timerDone) begin
          w_nextState = (r_filter == F_GREEN) ? DECIDE : PH_SETTLE;
        end
      end
      DECIDE: begin
        w_nextState = DONE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Classification priority: white, red, blue, green, none.
  always_comb begin
    w_color = COL_NONE;
    if (int'(r_redCnt) >= WHITE_TH) begin
      w_color = COL_WHITE;
    end else if (int'(r_redCnt) >= RED_TH) begin
      w_color = COL_RED;
    end else if (int'(r_blueCnt) >= BLUE_TH) begin
      w_color = COL_BLUE;
    end else if (int'(r_greenCnt) >= GREEN_MIN) begin
      w_color = COL_GREEN;
    end
  end

  // Phase timer, filter sequencing, saturating edge counters and result latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filter   <= F_RED;
      r_timer    <= '0;
      r_redCnt   <= '0;
      r_blueCnt  <= '0;
      r_greenCnt <= '0;
      r_color    <= COL_WHITE;
      r_redOut   <= '0;
      r_blueOut  <= '0;
      r_greenOut <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (measure) begin
            r_filter   <= F_RED;
            r_redCnt   <= '0;
            r_blueCnt  <= '0;
            r_greenCnt <= '0;
          end
        end
        START: begin
          r_busy   <= 1'b1;
          r_valid  <= 1'b0;
          r_filter <= F_RED;
          r_timer  <= SETTLE_LOAD;
        end
        PH_SETTLE: begin
          r_timer <= w_timerDone ? WINDOW_LOAD : r_timer - TW'(1);
        end
        PH_MEAS: begin
          if (w_rise) begin
            case (r_filter)
              F_RED: begin
                if (r_redCnt != CNT_MAX) r_redCnt <= r_redCnt + CNT_W'(1);
              end
              F_BLUE: begin
                if (r_blueCnt != CNT_MAX) r_blueCnt <= r_blueCnt + CNT_W'(1);
              end
              default: begin
                if (r_greenCnt != CNT_MAX) r_greenCnt <= r_greenCnt + CNT_W'(1);
              end
            endcase
          end
          if (w_timerDone) begin
            if (r_filter != F_GREEN) begin
              r_filter <= (r_filter == F_RED) ? F_BLUE : F_GREEN;
              r_timer  <= SETTLE_LOAD;
            end
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        DECIDE: begin
          r_color    <= w_color;
          r_redOut   <= r_redCnt;
          r_blueOut  <= r_blueCnt;
          r_greenOut <= r_greenCnt;
          r_busy     <= 1'b0;
          r_valid    <= 1'b1;
          r_filter   <= F_RED;
        end
        default: begin
          r_timer <= '0;
        end
      endcase
    end
  end

  assign S2    = (r_filter == F_GREEN);
  assign S3    = (r_filter != F_RED);
  assign busy  = r_busy;
  assign valid = r_valid;
  assign color = r_color;
  assign r_cnt = r_redOut;
  assign b_cnt = r_blueOut;
  assign g_cnt = r_greenOut;

endmodule

// File: tb/tb_colour_classifier.sv
// tb_colour_classifier
// Drives two colour_classifier instances (CNT_W=10 and CNT_W=6) from the same
// sensor/measure/reset stimulus with WINDOW=200, SETTLE=4. Expected counts come
// from a cycle-indexed model of the sensor waveform: the filtered level is the
// waveform delayed by the synchroniser (plus the deglitch qualifier when
// CSENSE_DEGLITCH_EN is defined), and its 0->1 transitions are counted over each
// filter's measurement window and then clamped to the counter range.

module tb_colour_classifier;

  localparam int WIN  = 200;
  localparam int SET  = 4;
  localparam int PH   = WIN + SET;
  localparam int LAT  = 3 * PH + 2;
  localparam int NCYC = 3 * PH + 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor;
  logic       measure;

  logic       S2A, S3A, busyA, validA;
  logic [2:0] colorA;
  logic [9:0] rA, bA, gA;

  logic       S2B, S3B, busyB, validB;
  logic [2:0] colorB;
  logic [5:0] rB, bB, gB;

  int checks = 0;
  int errors = 0;

  bit sArr [NCYC];

  typedef struct {
    int         tR;
    int         tB;
    int         tG;
    bit         glitch;
    logic [2:0] expA;
    logic [2:0] expB;
  } vec_t;

  vec_t vecs [6];

  colour_classifier #(.WINDOW(WIN), .SETTLE(SET), .CNT_W(10)) dutA (
    .clk(clk), .reset(reset), .sensor(sensor), .measure(measure),
    .S2(S2A), .S3(S3A), .busy(busyA), .color(colorA),
    .r_cnt(rA), .b_cnt(bA), .g_cnt(gA), .valid(validA)
  );

  colour_classifier #(.WINDOW(WIN), .SETTLE(SET), .CNT_W(6)) dutB (
    .clk(clk), .reset(reset), .sensor(sensor), .measure(measure),
    .S2(S2B), .S3(S3B), .busy(busyB), .color(colorB),
    .r_cnt(rB), .b_cnt(bB), .g_cnt(gB), .valid(validB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [2:0] classify(input int rc, input int bc, input int gc);
    if (rc >= 65) return 3'b000;
    if (rc >= 45) return 3'b001;
    if (bc >= 40) return 3'b011;
    if (gc >= 10) return 3'b010;
    return 3'b100;
  endfunction

  // Index j of sPad/lvl corresponds to waveform cycle j-4; cycles before the
  // accept edge are low.
  function automatic void modelCounts(input int cntW, output int rc, output int bc, output int gc);
    bit sPad [NCYC + 4];
    bit lvl  [NCYC + 4];
    int cnt  [3];
    int d;
    int maxCnt;
    maxCnt = (1 << cntW) - 1;
    for (int j = 0; j < NCYC + 4; j++) begin
      sPad[j] = (j < 4) ? 1'b0 : sArr[j - 4];
    end
`ifdef CSENSE_DEGLITCH_EN
    d = 3;
    for (int j = 0; j < NCYC + 4; j++) begin
      if (j == 0) begin
        lvl[j] = 1'b0;
      end else if (j >= 2 && sPad[j] == sPad[j - 1] && sPad[j - 1] == sPad[j - 2]) begin
        lvl[j] = sPad[j];
      end else begin
        lvl[j] = lvl[j - 1];
      end
    end
`else
    d = 2;
    for (int j = 0; j < NCYC + 4; j++) begin
      lvl[j] = sPad[j];
    end
`endif
    for (int p = 0; p < 3; p++) begin
      cnt[p] = 0;
      for (int e = p * PH + SET + 1; e <= (p + 1) * PH; e++) begin
        if (lvl[e - d + 4] && !lvl[e - d + 3]) cnt[p]++;
      end
      if (cnt[p] > maxCnt) cnt[p] = maxCnt;
    end
    rc = cnt[0];
    bc = cnt[1];
    gc = cnt[2];
  endfunction

  function automatic logic [2:0] modelColour(input int cntW);
    int rc, bc, gc;
    modelCounts(cntW, rc, bc, gc);
    return classify(rc, bc, gc);
  endfunction

  // Period 0 means held low; glitch adds an isolated 1-cycle high at k%8==6.
  task automatic fillPattern(input int tR, input int tB, input int tG, input bit glitch, input bit rndBits);
    int t;
    for (int k = 0; k < NCYC; k++) begin
      t = (k < PH) ? tR : (k < 2 * PH) ? tB : tG;
      if (rndBits) begin
        sArr[k] = 1'($urandom_range(0, 1));
      end else if (t == 0) begin
        sArr[k] = 1'b0;
      end else begin
        sArr[k] = ((k % t) < (t / 2));
      end
      if (glitch && (k % 8 == 6)) sArr[k] = 1'b1;
    end
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, " busyA"}, int'(busyA), 0);
    checkOutput({name, " validA"}, int'(validA), 0);
    checkOutput({name, " colorA"}, int'(colorA), 0);
    checkOutput({name, " S2S3A"}, int'({S2A, S3A}), 0);
    checkOutput({name, " countsA"}, int'(rA) + int'(bA) + int'(gA), 0);
    checkOutput({name, " validB"}, int'(validB), 0);
    checkOutput({name, " countsB"}, int'(rB) + int'(bB) + int'(gB), 0);
  endtask

  // Runs one measurement from the accept edge; abortAt>0 applies reset (with
  // measure also high) on that cycle instead of waiting for valid.
  task automatic applyStimulus(input string name, input bit pokeMeasure, input int abortAt);
    int latency;
    bit done;
    sensor  = 1'b0;
    measure = 1'b0;
    repeat (8) @(posedge clk);
    #1 measure = 1'b1;
    @(posedge clk);
    #1 measure = 1'b0;
    sensor  = sArr[0];
    latency = -1;
    done    = 1'b0;
    for (int k = 1; k <= LAT + 20 && !done; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        checkOutput({name, " busy@A+1"}, int'(busyA), 1);
        checkOutput({name, " valid@A+1"}, int'(validA), 0);
        checkOutput({name, " S2S3@A+1"}, int'({S2A, S3A}), 0);
      end
      if (k == SET + WIN / 2)      checkOutput({name, " S2S3 red"}, int'({S2A, S3A}), 0);
      if (k == PH + SET + 10)      checkOutput({name, " S2S3 blue"}, int'({S2A, S3A}), 1);
      if (k == 2 * PH + SET + 10)  checkOutput({name, " S2S3 green"}, int'({S2A, S3A}), 3);
      if (pokeMeasure) measure = (k == 100);
      if (k == abortAt) begin
        reset   = 1'b1;
        measure = 1'b1;
        @(posedge clk);
        #1;
        checkResetValues({name, " reset"});
        reset   = 1'b0;
        measure = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({name, " busy after reset+measure"}, int'(busyA), 0);
        done = 1'b1;
      end else begin
        if (validA) begin
          latency = k;
          done    = 1'b1;
        end
        sensor = (k < NCYC) ? sArr[k] : 1'b0;
      end
    end
    if (abortAt == 0) checkOutput({name, " latency"}, latency, LAT);
  endtask

  task automatic checkResults(input string name, input logic [2:0] expA, input logic [2:0] expB);
    int rc, bc, gc;
    modelCounts(10, rc, bc, gc);
    checkOutput({name, " r_cnt A"}, int'(rA), rc);
    checkOutput({name, " b_cnt A"}, int'(bA), bc);
    checkOutput({name, " g_cnt A"}, int'(gA), gc);
    checkOutput({name, " color A"}, int'(colorA), int'(expA));
    checkOutput({name, " busy A"}, int'(busyA), 0);
    modelCounts(6, rc, bc, gc);
    checkOutput({name, " r_cnt B"}, int'(rB), rc);
    checkOutput({name, " b_cnt B"}, int'(bB), bc);
    checkOutput({name, " g_cnt B"}, int'(gB), gc);
    checkOutput({name, " color B"}, int'(colorB), int'(expB));
    checkOutput({name, " valid B"}, int'(validB), 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput({name, " valid held"}, int'(validA), 1);
    checkOutput({name, " color held"}, int'(colorA), int'(expA));
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef CSENSE_DEGLITCH_EN
    vecs[0] = '{2, 2, 2, 1'b0, 3'b100, 3'b100};
    vecs[1] = '{4, 8, 8, 1'b0, 3'b010, 3'b010};
    vecs[2] = '{8, 4, 8, 1'b0, 3'b010, 3'b010};
    vecs[3] = '{8, 8, 4, 1'b0, 3'b100, 3'b100};
    vecs[4] = '{0, 0, 0, 1'b0, 3'b100, 3'b100};
    vecs[5] = '{8, 8, 8, 1'b1, 3'b010, 3'b010};
`else
    vecs[0] = '{2, 2, 2, 1'b0, 3'b000, 3'b001};
    vecs[1] = '{4, 8, 8, 1'b0, 3'b001, 3'b001};
    vecs[2] = '{8, 4, 8, 1'b0, 3'b011, 3'b011};
    vecs[3] = '{8, 8, 4, 1'b0, 3'b010, 3'b010};
    vecs[4] = '{0, 0, 0, 1'b0, 3'b100, 3'b100};
    vecs[5] = '{8, 8, 8, 1'b1, 3'b001, 3'b001};
`endif

    reset   = 1'b1;
    measure = 1'b0;
    sensor  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("power-up");
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      fillPattern(vecs[i].tR, vecs[i].tB, vecs[i].tG, vecs[i].glitch, 1'b0);
      applyStimulus($sformatf("vec%0d", i), (i == 1), 0);
      checkResults($sformatf("vec%0d", i), vecs[i].expA, vecs[i].expB);
    end

    fillPattern(2, 4, 6, 1'b0, 1'b0);
    applyStimulus("midreset", 1'b0, PH + 50);
    applyStimulus("after reset", 1'b0, 0);
    checkResults("after reset", modelColour(10), modelColour(6));

    for (int i = 0; i < 4; i++) begin
      fillPattern($urandom_range(2, 12), $urandom_range(2, 12), $urandom_range(2, 12),
                  1'($urandom_range(0, 1)), (i >= 2));
      applyStimulus($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 0);
      checkResults($sformatf("rand%0d", i), modelColour(10), modelColour(6));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
